// File: rtl/flash_dma_pkg.sv
// Shared definitions for the flash_dma block: register offsets, CTRL/STATUS bit
// positions, the sequencer state encoding and a STATUS word packing helper.
// Imported by flash_dma_regs and flash_dma.
package flash_dma_pkg;

   // Register map (reg_addr values)
   localparam logic [1:0] REG_SRC   = 2'd0;
   localparam logic [1:0] REG_DST   = 2'd1;
   localparam logic [1:0] REG_COUNT = 2'd2;
   localparam logic [1:0] REG_CTRL  = 2'd3;

   // CTRL write bits
   localparam int CTRL_START   = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int CTRL_IRQ_ACK = 2;

   // STATUS read bits
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;
   localparam int STAT_IRQ     = 3;

   // Flash byte address width seen on the arbiter reader port
   localparam int FLASH_ADDR_W = 24;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   // Packs the STATUS register; unused upper bits read as zero.
   function automatic logic [31:0] status_word(input logic busy,
                                               input logic done,
                                               input logic aborted,
                                               input logic irq_pending);
      logic [31:0] w;
      w               = '0;
      w[STAT_BUSY]    = busy;
      w[STAT_DONE]    = done;
      w[STAT_ABORTED] = aborted;
      w[STAT_IRQ]     = irq_pending;
      return w;
   endfunction

endpackage

// File: rtl/flash_dma_regs.sv
// CPU register front end for flash_dma: decodes register writes into load
// strobes and CTRL command pulses, stores the done/aborted/irq_pending status
// flags and drives the combinational readback mux.
// The SRC/DST/COUNT counters themselves live in flash_dma; this block only
// produces their load strobes (suppressed while busy) and reads them back live.
//
// Optional feature macro: FLASH_DMA_IRQ_EN (irq_pending flag, irq output,
// CTRL irq_ack). Without it irq is tied low and STATUS bit3 reads 0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   reg_addr/wr_en/wr_data     CPU register write port
//   reg_rd_data                combinational readback of reg_addr
//   busy                       sequencer not idle
//   src/dst/count              live counter values for readback
//   set_done/set_aborted       status flag set requests from the sequencer
//   clear_flags                clear done/aborted (accepted start)
//   src_load.. count_value     counter load strobes and values
//   start/abort                CTRL command pulses
//   irq                        interrupt output
module flash_dma_regs
   import flash_dma_pkg::*;
#(
   parameter int RAM_ADDR_W = 16,
   parameter int COUNT_W    = 16
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              reg_addr,
   input  logic                    reg_wr_en,
   input  logic [31:0]             reg_wr_data,
   output logic [31:0]             reg_rd_data,
   input  logic                    busy,
   input  logic [FLASH_ADDR_W-1:0] src,
   input  logic [RAM_ADDR_W-1:0]   dst,
   input  logic [COUNT_W-1:0]      count,
   input  logic                    set_done,
   input  logic                    set_aborted,
   input  logic                    clear_flags,
   output logic                    src_load,
   output logic [FLASH_ADDR_W-1:0] src_value,
   output logic                    dst_load,
   output logic [RAM_ADDR_W-1:0]   dst_value,
   output logic                    count_load,
   output logic [COUNT_W-1:0]      count_value,
   output logic                    start,
   output logic                    abort,
   output logic                    irq
);

   logic done;
   logic aborted;
   logic irq_pending;
   logic ctrl_wr;
   logic unused_wr_bits;

   // Configuration writes are dropped while a transfer runs so the live
   // counters cannot be corrupted mid-copy. SRC is always word aligned.
   assign ctrl_wr     = reg_wr_en && (reg_addr == REG_CTRL);
   assign start       = ctrl_wr && reg_wr_data[CTRL_START];
   assign abort       = ctrl_wr && reg_wr_data[CTRL_ABORT];
   assign src_load    = reg_wr_en && (reg_addr == REG_SRC) && !busy;
   assign dst_load    = reg_wr_en && (reg_addr == REG_DST) && !busy;
   assign count_load  = reg_wr_en && (reg_addr == REG_COUNT) && !busy;
   assign src_value   = {reg_wr_data[FLASH_ADDR_W-1:2], 2'b00};
   assign dst_value   = reg_wr_data[RAM_ADDR_W-1:0];
   assign count_value = reg_wr_data[COUNT_W-1:0];
   assign unused_wr_bits = ^reg_wr_data[31:FLASH_ADDR_W];

   // Completion flags: clear on an accepted start, then a same-cycle set
   // (zero-length start) takes priority over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         if (clear_flags) begin
            done    <= 1'b0;
            aborted <= 1'b0;
         end
         if (set_done) begin
            done <= 1'b1;
         end
         if (set_aborted) begin
            aborted <= 1'b1;
         end
      end
   end

`ifdef FLASH_DMA_IRQ_EN
   logic irq_ack;
   assign irq_ack = ctrl_wr && reg_wr_data[CTRL_IRQ_ACK];

   // A completion event in the same cycle as an acknowledge must not be lost,
   // so setting wins over clearing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_pending <= 1'b0;
      end else if (set_done || set_aborted) begin
         irq_pending <= 1'b1;
      end else if (irq_ack) begin
         irq_pending <= 1'b0;
      end
   end
`else
   assign irq_pending = 1'b0;
`endif

   assign irq = irq_pending;

   // Readback mux; counters are shown live while the transfer runs.
   always_comb begin
      reg_rd_data = '0;
      case (reg_addr)
         REG_SRC:   reg_rd_data = 32'(src);
         REG_DST:   reg_rd_data = 32'(dst);
         REG_COUNT: reg_rd_data = 32'(count);
         default:   reg_rd_data = status_word(busy, done, aborted, irq_pending);
      endcase
   end

endmodule

// File: rtl/flash_dma.sv
// flash_dma: CPU-programmed sequencer copying COUNT 32-bit words from QSPI flash
// (via one flash_arbiter reader port) into RAM, one word at a time.
//
// Optional feature macro: FLASH_DMA_IRQ_EN (transfer-complete interrupt).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   reg_addr             register select: 0 SRC, 1 DST, 2 COUNT, 3 CTRL/STATUS
//   reg_wr_en/wr_data    one-cycle register write strobe and data
//   reg_rd_data          combinational readback
//   flash_read_address   flash byte address (user-relative)
//   flash_read_en        read request to arbiter
//   flash_size           constant 1 (32-bit reads)
//   flash_ready          one-cycle read-data-valid pulse from arbiter
//   flash_read_data      arbiter read data
//   ram_write_address    RAM word address
//   ram_write_data       RAM write data
//   ram_write_en         write request, held until ram_write_ready
//   ram_write_ready      RAM accepted the write this cycle
//   irq                  transfer-complete interrupt
module flash_dma
   import flash_dma_pkg::*;
#(
   parameter int RAM_ADDR_W = 16,
   parameter int COUNT_W    = 16
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              reg_addr,
   input  logic                    reg_wr_en,
   input  logic [31:0]             reg_wr_data,
   output logic [31:0]             reg_rd_data,
   output logic [FLASH_ADDR_W-1:0] flash_read_address,
   output logic                    flash_read_en,
   output logic                    flash_size,
   input  logic                    flash_ready,
   input  logic [31:0]             flash_read_data,
   output logic [RAM_ADDR_W-1:0]   ram_write_address,
   output logic [31:0]             ram_write_data,
   output logic                    ram_write_en,
   input  logic                    ram_write_ready,
   output logic                    irq
);

   state_t                  state;
   state_t                  next_state;
   logic [FLASH_ADDR_W-1:0] src;
   logic [RAM_ADDR_W-1:0]   dst;
   logic [COUNT_W-1:0]      count;
   logic [31:0]             data_reg;
   logic                    abort_pending;
   logic                    abort_now;
   logic                    busy;
   logic                    set_done;
   logic                    set_aborted;
   logic                    clear_flags;
   logic                    capture;
   logic                    advance;
   logic                    src_load;
   logic                    dst_load;
   logic                    count_load;
   logic [FLASH_ADDR_W-1:0] src_value;
   logic [RAM_ADDR_W-1:0]   dst_value;
   logic [COUNT_W-1:0]      count_value;
   logic                    start;
   logic                    abort;

   flash_dma_regs #(
      .RAM_ADDR_W (RAM_ADDR_W),
      .COUNT_W    (COUNT_W)
   ) u_regs (
      .clk         (clk),
      .reset       (reset),
      .reg_addr    (reg_addr),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_data (reg_wr_data),
      .reg_rd_data (reg_rd_data),
      .busy        (busy),
      .src         (src),
      .dst         (dst),
      .count       (count),
      .set_done    (set_done),
      .set_aborted (set_aborted),
      .clear_flags (clear_flags),
      .src_load    (src_load),
      .src_value   (src_value),
      .dst_load    (dst_load),
      .dst_value   (dst_value),
      .count_load  (count_load),
      .count_value (count_value),
      .start       (start),
      .abort       (abort),
      .irq         (irq)
   );

   assign busy       = (state != ST_IDLE);
   // An abort is remembered until the in-flight read or write has finished.
   assign abort_now  = abort_pending || abort;
   assign flash_size = 1'b1;

   // Address/data buses are only driven while their request is active, so
   // they read as zero when idle and immediately after reset.
   assign flash_read_address = flash_read_en ? src : '0;
   assign ram_write_address  = ram_write_en ? dst : '0;
   assign ram_write_data     = ram_write_en ? data_reg : '0;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and request outputs. GAP exists so that flash_read_en is low
   // for at least one cycle between words, because the arbiter reacts to the
   // rising edge of the request.
   always_comb begin
      next_state    = state;
      set_done      = 1'b0;
      set_aborted   = 1'b0;
      clear_flags   = 1'b0;
      capture       = 1'b0;
      advance       = 1'b0;
      flash_read_en = 1'b0;
      ram_write_en  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               clear_flags = 1'b1;
               if (count != '0) begin
                  next_state = ST_ISSUE;
               end else begin
                  set_done = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            flash_read_en = 1'b1;
            next_state    = ST_WAIT;
         end
         ST_WAIT: begin
            flash_read_en = 1'b1;
            if (flash_ready) begin
               if (abort_now) begin
                  next_state  = ST_IDLE;
                  set_aborted = 1'b1;
               end else begin
                  capture    = 1'b1;
                  next_state = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            ram_write_en = 1'b1;
            if (ram_write_ready) begin
               advance = 1'b1;
               if (abort_now) begin
                  next_state  = ST_IDLE;
                  set_aborted = 1'b1;
               end else begin
                  next_state = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (count == '0) begin
               next_state = ST_IDLE;
               set_done   = 1'b1;
            end else if (abort_now) begin
               next_state  = ST_IDLE;
               set_aborted = 1'b1;
            end else begin
               next_state = ST_ISSUE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Transfer counters: CPU loads only happen while idle, advancing only
   // while busy, so the two never collide. Wrap is the natural modulo.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src   <= '0;
         dst   <= '0;
         count <= '0;
      end else if (advance) begin
         src   <= src + FLASH_ADDR_W'(4);
         dst   <= dst + RAM_ADDR_W'(1);
         count <= count - COUNT_W'(1);
      end else begin
         if (src_load) begin
            src <= src_value;
         end
         if (dst_load) begin
            dst <= dst_value;
         end
         if (count_load) begin
            count <= count_value;
         end
      end
   end

   // Word buffer between the flash read and the RAM write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg <= '0;
      end else if (capture) begin
         data_reg <= flash_read_data;
      end
   end

   // Abort latch: armed by an abort while busy, cleared on return to idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         abort_pending <= 1'b0;
      end else if (next_state == ST_IDLE) begin
         abort_pending <= 1'b0;
      end else if (abort && busy) begin
         abort_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_flash_dma.sv
// Testbench for flash_dma: register table vectors, then directed transfer
// sequences against a small flash responder and RAM responder model.
module tb_flash_dma;

   localparam logic [1:0] A_SRC   = 2'd0;
   localparam logic [1:0] A_DST   = 2'd1;
   localparam logic [1:0] A_COUNT = 2'd2;
   localparam logic [1:0] A_CTRL  = 2'd3;
`ifdef FLASH_DMA_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  reg_addr = '0;
   logic        reg_wr_en = 1'b0;
   logic [31:0] reg_wr_data = '0;
   logic [31:0] reg_rd_data;
   logic [23:0] flash_read_address;
   logic        flash_read_en;
   logic        flash_size;
   logic        flash_ready = 1'b0;
   logic [31:0] flash_read_data = '0;
   logic [15:0] ram_write_address;
   logic [31:0] ram_write_data;
   logic        ram_write_en;
   logic        ram_write_ready = 1'b0;
   logic        irq;

   int errors = 0;
   int checks = 0;

   // responder / monitor state
   bit          flash_auto = 1'b1;
   bit          req_open = 1'b0;
   int          req_lat = 0;
   logic [23:0] req_addr = '0;
   int          stall_left = 0;
   int          gap_violations = 0;
   int          read_en_cycles = 0;
   int          write_en_cycles = 0;
   logic [31:0] read_log[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rexp;
   } reg_vec_t;
   reg_vec_t vecs[10];

   flash_dma dut (
      .clk                (clk),
      .reset              (reset),
      .reg_addr           (reg_addr),
      .reg_wr_en          (reg_wr_en),
      .reg_wr_data        (reg_wr_data),
      .reg_rd_data        (reg_rd_data),
      .flash_read_address (flash_read_address),
      .flash_read_en      (flash_read_en),
      .flash_size         (flash_size),
      .flash_ready        (flash_ready),
      .flash_read_data    (flash_read_data),
      .ram_write_address  (ram_write_address),
      .ram_write_data     (ram_write_data),
      .ram_write_en       (ram_write_en),
      .ram_write_ready    (ram_write_ready),
      .irq                (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] flash_model(input logic [23:0] a);
      return {8'hC3, a ^ 24'h5A5A5A};
   endfunction

   // Flash arbiter stand-in: answers each rising request after 3 cycles.
   initial begin
      forever begin
         @(negedge clk);
         read_en_cycles  += int'(flash_read_en);
         write_en_cycles += int'(ram_write_en);
         if (flash_auto) begin
            if (flash_ready && flash_read_en) gap_violations++;
            flash_ready = 1'b0;
            if (req_open) begin
               if (req_lat == 0) begin
                  flash_ready     = 1'b1;
                  flash_read_data = flash_model(req_addr);
                  req_open        = 1'b0;
               end else begin
                  req_lat--;
               end
            end else if (flash_read_en) begin
               req_open = 1'b1;
               req_lat  = 2;
               req_addr = flash_read_address;
               read_log.push_back(32'(flash_read_address));
            end
         end
      end
   end

   // RAM stand-in: accepts writes, optionally after stall_left refusals.
   initial begin
      forever begin
         @(negedge clk);
         if (ram_write_en) begin
            if (stall_left > 0) begin
               ram_write_ready = 1'b0;
               stall_left--;
            end else begin
               ram_write_ready = 1'b1;
               wr_addr_log.push_back(32'(ram_write_address));
               wr_data_log.push_back(ram_write_data);
            end
         end else begin
            ram_write_ready = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      reg_addr    = a;
      reg_wr_data = d;
      reg_wr_en   = 1'b1;
      @(negedge clk);
      reg_wr_en   = 1'b0;
      reg_wr_data = '0;
   endtask

   task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
      reg_addr = a;
      #1;
      d = reg_rd_data;
   endtask

   task automatic applyStimulus(input reg_vec_t v);
      reg_write(v.addr, v.wdata);
   endtask

   task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] e);
      logic [31:0] d;
      reg_read(a, d);
      checkOutput(name, d, e);
   endtask

   // STATUS bits busy/done/aborted only; irq bit checked separately.
   task automatic check_status(input string name, input logic [2:0] e);
      logic [31:0] d;
      reg_read(A_CTRL, d);
      checkOutput(name, 32'(d[2:0]), 32'(e));
   endtask

   task automatic wait_idle(input string name);
      logic [31:0] d;
      int n;
      n = 0;
      do begin
         @(negedge clk);
         reg_read(A_CTRL, d);
         n++;
      end while (d[0] && n < 400);
      checkOutput({name, "_idle_timeout"}, 32'(d[0]), 32'h0);
   endtask

   task automatic wait_read_en(input string name);
      int n;
      n = 0;
      while (!flash_read_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_read_en_timeout"}, 32'(flash_read_en), 32'h1);
   endtask

   task automatic wait_write_en(input string name);
      int n;
      n = 0;
      while (!ram_write_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_write_en_timeout"}, 32'(ram_write_en), 32'h1);
   endtask

   task automatic clear_logs();
      read_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
   endtask

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hBAD0BAD0;
   endfunction

   initial begin
      logic [31:0] a0, d0, s;
      int base_r, base_w, stable_bad;

      vecs[0] = '{A_SRC,   32'h12345677, 32'h00345674};
      vecs[1] = '{A_SRC,   32'hFFFFFFFF, 32'h00FFFFFC};
      vecs[2] = '{A_DST,   32'hABCD1234, 32'h00001234};
      vecs[3] = '{A_DST,   32'h00000040, 32'h00000040};
      vecs[4] = '{A_COUNT, 32'h0001FFFF, 32'h0000FFFF};
      vecs[5] = '{A_COUNT, 32'h00000005, 32'h00000005};
      vecs[6] = '{A_CTRL,  32'h00000002, 32'h00000000};
      vecs[7] = '{A_CTRL,  32'h00000004, 32'h00000000};
      vecs[8] = '{A_SRC,   32'h00000101, 32'h00000100};
      vecs[9] = '{A_COUNT, 32'h00000000, 32'h00000000};

      // ---- reset state
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_flash_read_en", 32'(flash_read_en), 32'h0);
      checkOutput("rst_ram_write_en", 32'(ram_write_en), 32'h0);
      checkOutput("rst_irq", 32'(irq), 32'h0);
      checkOutput("flash_size", 32'(flash_size), 32'h1);
      check_reg("rst_src", A_SRC, 32'h0);
      check_reg("rst_dst", A_DST, 32'h0);
      check_reg("rst_count", A_COUNT, 32'h0);
      check_reg("rst_status", A_CTRL, 32'h0);

      // ---- register table
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         check_reg($sformatf("table%0d", i), vecs[i].addr, vecs[i].rexp);
      end

      // ---- COUNT=0 start: done next cycle, no traffic
      base_r = read_en_cycles;
      base_w = write_en_cycles;
      reg_write(A_CTRL, 32'h1);
      check_status("cnt0_status", 3'b010);
      repeat (5) @(negedge clk);
      checkOutput("cnt0_read_en_cycles", 32'(read_en_cycles - base_r), 32'h0);
      checkOutput("cnt0_write_en_cycles", 32'(write_en_cycles - base_w), 32'h0);

      // ---- basic 3-word transfer
      clear_logs();
      reg_write(A_SRC, 32'h00000100);
      reg_write(A_DST, 32'h00000040);
      reg_write(A_COUNT, 32'h3);
      reg_write(A_CTRL, 32'h1);
      check_status("t1_busy", 3'b001);
      checkOutput("t1_read_en_first", 32'(flash_read_en), 32'h1);
      wait_idle("t1");
      check_status("t1_done", 3'b010);
      checkOutput("t1_nreads", 32'(read_log.size()), 32'd3);
      checkOutput("t1_nwrites", 32'(wr_addr_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("t1_read%0d", i), q_at(read_log, i), 32'h100 + 32'(4 * i));
         checkOutput($sformatf("t1_waddr%0d", i), q_at(wr_addr_log, i), 32'h40 + 32'(i));
         checkOutput($sformatf("t1_wdata%0d", i), q_at(wr_data_log, i),
                     flash_model(24'h100 + 24'(4 * i)));
      end
      check_reg("t1_src_end", A_SRC, 32'h10C);
      check_reg("t1_dst_end", A_DST, 32'h43);
      check_reg("t1_count_end", A_COUNT, 32'h0);
      checkOutput("t1_gap_violations", 32'(gap_violations), 32'h0);

      // ---- RAM stall: request held stable, no new flash read
      clear_logs();
      reg_write(A_SRC, 32'h00000200);
      reg_write(A_DST, 32'h00000080);
      reg_write(A_COUNT, 32'h2);
      stall_left = 10;
      reg_write(A_CTRL, 32'h1);
      wait_write_en("stall");
      a0 = 32'(ram_write_address);
      d0 = ram_write_data;
      checkOutput("stall_addr", a0, 32'h80);
      checkOutput("stall_data", d0, flash_model(24'h200));
      stable_bad = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (!(ram_write_en && 32'(ram_write_address) == a0 && ram_write_data == d0
               && !flash_read_en)) stable_bad++;
      end
      checkOutput("stall_stable", 32'(stable_bad), 32'h0);
      wait_idle("stall");
      checkOutput("stall_nwrites", 32'(wr_addr_log.size()), 32'd2);
      checkOutput("stall_waddr1", q_at(wr_addr_log, 1), 32'h81);
      checkOutput("stall_wdata1", q_at(wr_data_log, 1), flash_model(24'h204));
      checkOutput("stall_read1", q_at(read_log, 1), 32'h204);

      // ---- address wrap on both SRC and DST
      clear_logs();
      reg_write(A_SRC, 32'h00FFFFFC);
      reg_write(A_DST, 32'h0000FFFF);
      reg_write(A_COUNT, 32'h2);
      reg_write(A_CTRL, 32'h1);
      wait_idle("wrap");
      checkOutput("wrap_read0", q_at(read_log, 0), 32'hFFFFFC);
      checkOutput("wrap_read1", q_at(read_log, 1), 32'h000000);
      checkOutput("wrap_waddr0", q_at(wr_addr_log, 0), 32'hFFFF);
      checkOutput("wrap_waddr1", q_at(wr_addr_log, 1), 32'h0000);
      check_reg("wrap_src_end", A_SRC, 32'h4);
      check_reg("wrap_dst_end", A_DST, 32'h1);
      check_status("wrap_done", 3'b010);
      checkOutput("wrap_gap_violations", 32'(gap_violations), 32'h0);

      // ---- async reset during WRITE
      reg_write(A_SRC, 32'h00000400);
      reg_write(A_DST, 32'h00000010);
      reg_write(A_COUNT, 32'h2);
      stall_left = 50;
      reg_write(A_CTRL, 32'h1);
      wait_write_en("rstw");
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rstw_ram_write_en", 32'(ram_write_en), 32'h0);
      checkOutput("rstw_ram_write_address", 32'(ram_write_address), 32'h0);
      checkOutput("rstw_ram_write_data", ram_write_data, 32'h0);
      checkOutput("rstw_flash_read_en", 32'(flash_read_en), 32'h0);
      checkOutput("rstw_flash_read_address", 32'(flash_read_address), 32'h0);
      checkOutput("rstw_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      stall_left = 0;
      check_status("rstw_status", 3'b000);
      check_reg("rstw_src", A_SRC, 32'h0);

      // ---- abort while waiting on flash (manual flash responses from here)
      flash_auto = 1'b0;
      clear_logs();
      reg_write(A_SRC, 32'h00000300);
      reg_write(A_DST, 32'h00000090);
      reg_write(A_COUNT, 32'h4);
      reg_write(A_CTRL, 32'h1);
      wait_read_en("abort");
      reg_write(A_CTRL, 32'h2);
      reg_write(A_COUNT, 32'h77);
      check_reg("abort_count_write_ignored", A_COUNT, 32'h4);
      check_status("abort_still_busy", 3'b001);
      @(negedge clk);
      flash_ready     = 1'b1;
      flash_read_data = 32'hDEADBEEF;
      @(negedge clk);
      flash_ready = 1'b0;
      check_status("abort_status", 3'b100);
      checkOutput("abort_read_en_low", 32'(flash_read_en), 32'h0);
      repeat (3) @(negedge clk);
      checkOutput("abort_nwrites", 32'(wr_addr_log.size()), 32'h0);
      check_reg("abort_count", A_COUNT, 32'h4);
      check_reg("abort_src", A_SRC, 32'h300);

      // ---- late flash_ready after reset is ignored
      reg_write(A_SRC, 32'h00000500);
      reg_write(A_COUNT, 32'h1);
      reg_write(A_CTRL, 32'h1);
      wait_read_en("late");
      #2;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      base_r = read_en_cycles;
      base_w = write_en_cycles;
      flash_ready     = 1'b1;
      flash_read_data = 32'h12345678;
      @(negedge clk);
      flash_ready = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("late_write_en_cycles", 32'(write_en_cycles - base_w), 32'h0);
      checkOutput("late_read_en_cycles", 32'(read_en_cycles - base_r), 32'h0);
      check_status("late_status", 3'b000);

      // ---- interrupt behaviour (tied low without the feature)
      reg_write(A_CTRL, 32'h4);
      checkOutput("irq_after_ack0", 32'(irq), 32'h0);
      reg_write(A_COUNT, 32'h0);
      reg_write(A_CTRL, 32'h1);
      reg_read(A_CTRL, s);
      checkOutput("irq_after_done", 32'(irq), 32'(IRQ_ON));
      checkOutput("irq_status_bit", 32'(s[3]), 32'(IRQ_ON));
      checkOutput("irq_done_bit", 32'(s[1]), 32'h1);
      reg_write(A_CTRL, 32'h4);
      reg_read(A_CTRL, s);
      checkOutput("irq_after_ack", 32'(irq), 32'h0);
      checkOutput("irq_status_after_ack", 32'(s[3]), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
